// File: rtl/sprite_compositor.sv
// Two-stage per-pixel sprite compositor: double-buffered sprite descriptors tested against
// one shared square mask bitmap, with overlaps resolved so that the lowest sprite index wins.
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_DIM  = 127,
  parameter int ROW_W       = 11,
  parameter int COL_W       = 12,
  parameter int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                             clock_162,
  input  logic                             rst,
  input  logic [SPRITE_DIM*SPRITE_DIM-1:0] sprite,
  input  logic [11:0]                      bg_color,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [ROW_W-1:0]                 wr_row,
  input  logic [COL_W-1:0]                 wr_col,
  input  logic                             wr_en,
  input  logic [11:0]                      wr_color,
  input  logic                             frame_start,
  output logic                             commit_done,
  input  logic                             pix_valid,
  input  logic [ROW_W-1:0]                 pix_row,
  input  logic [COL_W-1:0]                 pix_col,
  output logic                             out_valid,
  output logic                             out_hit,
  output logic [IDX_W-1:0]                 out_idx,
  output logic [11:0]                      out_color
);

  localparam int R       = (SPRITE_DIM - 1) / 2;
  localparam int MASK_N  = SPRITE_DIM * SPRITE_DIM;
  localparam int DIM_W   = (SPRITE_DIM > 1) ? $clog2(SPRITE_DIM) : 1;
  localparam int MASK_AW = (MASK_N > 1) ? $clog2(MASK_N) : 1;

  localparam logic signed [ROW_W+1:0] R_ROW   = (ROW_W+2)'(R);
  localparam logic signed [ROW_W+1:0] DIM_ROW = (ROW_W+2)'(SPRITE_DIM);
  localparam logic signed [COL_W+1:0] R_COL   = (COL_W+2)'(R);
  localparam logic signed [COL_W+1:0] DIM_COL = (COL_W+2)'(SPRITE_DIM);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             en;
    logic [11:0]      color;
  } desc_t;

  localparam desc_t DESC_RST = '{row: '0, col: '0, en: 1'b0, color: 12'hFFF};

  // Offsets are widened by two bits so a centre near 0 gives a negative offset
  // instead of wrapping onto the far edge of the screen.
  function automatic logic signed [ROW_W+1:0] row_off(input logic [ROW_W-1:0] p,
                                                       input logic [ROW_W-1:0] c);
    return $signed({2'b00, p}) - $signed({2'b00, c}) + R_ROW;
  endfunction

  function automatic logic signed [COL_W+1:0] col_off(input logic [COL_W-1:0] p,
                                                       input logic [COL_W-1:0] c);
    return $signed({2'b00, p}) - $signed({2'b00, c}) + R_COL;
  endfunction

  function automatic logic row_in(input logic signed [ROW_W+1:0] d);
    return !d[ROW_W+1] && (d < DIM_ROW);
  endfunction

  function automatic logic col_in(input logic signed [COL_W+1:0] d);
    return !d[COL_W+1] && (d < DIM_COL);
  endfunction

  function automatic logic mask_bit(input logic [MASK_N-1:0]  m,
                                    input logic [DIM_W-1:0]   r,
                                    input logic [DIM_W-1:0]   c);
    logic [MASK_AW-1:0] a;
    a = MASK_AW'(r) * MASK_AW'(SPRITE_DIM) + MASK_AW'(c);
    return m[a];
  endfunction

  desc_t shadow [NUM_SPRITES];
  desc_t active [NUM_SPRITES];
  logic  idx_ok;

  generate
    if (NUM_SPRITES == (1 << IDX_W)) begin : g_idx_full
      assign idx_ok = 1'b1;
    end else begin : g_idx_part
      assign idx_ok = (wr_idx < IDX_W'(NUM_SPRITES));
    end
  endgenerate

  // Writes are refused during the commit cycle so shadow and active never race.
  assign wr_ready = rst & ~frame_start;

  always_ff @(posedge clock_162 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= DESC_RST;
        active[i] <= DESC_RST;
      end
      commit_done <= 1'b0;
    end else begin
      commit_done <= frame_start;
      if (frame_start) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          active[i] <= shadow[i];
        end
      end else if (wr_valid && wr_ready && idx_ok) begin
        shadow[wr_idx] <= '{row: wr_row, col: wr_col, en: wr_en, color: wr_color};
      end
    end
  end

  logic signed [ROW_W+1:0] dr [NUM_SPRITES];
  logic signed [COL_W+1:0] dc [NUM_SPRITES];

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dr[i] = row_off(pix_row, active[i].row);
      dc[i] = col_off(pix_col, active[i].col);
    end
  end

  // ---- stage 1: per-sprite offsets, window flags and descriptor snapshot ----
  logic                   vld_p1;
  logic [NUM_SPRITES-1:0] cand_p1;
  logic [DIM_W-1:0]       dr_p1    [NUM_SPRITES];
  logic [DIM_W-1:0]       dc_p1    [NUM_SPRITES];
  logic [11:0]            color_p1 [NUM_SPRITES];

  always_ff @(posedge clock_162 or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      cand_p1 <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        dr_p1[i]    <= '0;
        dc_p1[i]    <= '0;
        color_p1[i] <= '0;
      end
    end else begin
      vld_p1 <= pix_valid;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        cand_p1[i]  <= active[i].en && row_in(dr[i]) && col_in(dc[i]);
        dr_p1[i]    <= dr[i][DIM_W-1:0];
        dc_p1[i]    <= dc[i][DIM_W-1:0];
        color_p1[i] <= active[i].color;
      end
    end
  end

  logic             win_hit;
  logic [IDX_W-1:0] win_idx;
  logic [11:0]      win_color;

  // Scanning from the top index down lets the lowest hitting index overwrite the rest.
  always_comb begin
    win_hit   = 1'b0;
    win_idx   = '0;
    win_color = bg_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (cand_p1[i] && mask_bit(sprite, dr_p1[i], dc_p1[i])) begin
        win_hit   = 1'b1;
        win_idx   = IDX_W'(i);
        win_color = color_p1[i];
      end
    end
  end

  // ---- stage 2: mask lookup, priority select, blanking into output registers ----
  always_ff @(posedge clock_162 or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
      out_color <= '0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_hit   <= win_hit;
        out_idx   <= win_idx;
        out_color <= win_color;
      end else begin
        out_hit   <= 1'b0;
        out_idx   <= '0;
        out_color <= 12'h000;
      end
    end
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised per-pixel sprite compositor between the VGA timing driver and the colour outputs of the 1600x1200 @ 162 MHz display path. It holds NUM_SPRITES runtime-writable sprite descriptors (centre, enable, colour), double-buffered and committed at frame boundaries. For each active pixel it tests every sprite against the shared circular mask bitmap, resolves overlaps by fixed priority, and returns a 12-bit RGB colour two cycles later. It replaces fixed, hard-wired sprite positions with positions the simulation core can move every frame.

## Interface
- NUM_SPRITES, 4, number of sprite descriptors (1..16)
- SPRITE_DIM, 127, mask side length in pixels (odd); R = (SPRITE_DIM-1)/2
- ROW_W, 11, pixel row width
- COL_W, 12, pixel column width
- IDX_W, $clog2(NUM_SPRITES) (min 1), sprite index width

- clock_162  in  1  pixel clock, 162 MHz
- rst  in  1  asynchronous, active-low reset
- sprite  in  SPRITE_DIM*SPRITE_DIM  shared mask; bit r*SPRITE_DIM+c = mask row r, column c
- bg_color  in  12  background RGB 4:4:4
- wr_valid  in  1  descriptor write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_idx  in  IDX_W  target sprite
- wr_row  in  ROW_W  centre row
- wr_col  in  COL_W  centre column
- wr_en  in  1  sprite enable
- wr_color  in  12  sprite RGB
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- commit_done  out  1  one-cycle pulse, cycle after commit
- pix_valid  in  1  pixel is in active area
- pix_row  in  ROW_W  current pixel row
- pix_col  in  COL_W  current pixel column
- out_valid  out  1  output pixel valid
- out_hit  out  1  some sprite covers the pixel
- out_idx  out  IDX_W  winning sprite index (0 if no hit)
- out_color  out  12  final RGB

## Operation
- Two descriptor banks: shadow (written by port) and active (used for compositing).
- Write: on wr_valid && wr_ready, shadow[wr_idx] <= {wr_row, wr_col, wr_en, wr_color}. wr_idx >= NUM_SPRITES: accepted, discarded.
- wr_ready = 0 in any cycle frame_start = 1 (and during reset), else 1. Requester holds wr_valid/data until accepted.
- Commit: on frame_start, active <= shadow (all entries, same edge); commit_done = 1 next cycle.
- Hit test, sprite i: dr = pix_row - row_i + R, dc = pix_col - col_i + R, computed signed at ROW_W+2 / COL_W+2 bits; inside_i = en_i && 0 <= dr < SPRITE_DIM && 0 <= dc < SPRITE_DIM && sprite[dr*SPRITE_DIM+dc]. No wrap-around: a centre near 0 never hits pixels at the far edge.
- Priority: lowest index with inside_i wins; out_color = its colour, out_hit = 1. No hit: out_color = bg_color, out_hit = 0, out_idx = 0.
- pix_valid = 0: out_valid = 0, out_hit = 0, out_color = 12'h000 (blanking black).
- Reset values: all shadow/active entries row 0, col 0, en 0, color 12'hFFF; out_valid, out_hit, out_idx, out_color, commit_done = 0; pipeline cleared.

## Timing
- Stage 1 (edge t+1): register pixel coords, pix_valid, per-sprite dr/dc and range flags.
- Stage 2 (edge t+2): mask lookup, priority encode, colour select into output registers.
- Latency: pix_valid at cycle t -> out_valid at t+2; throughput 1 pixel/cycle, no stalls.
- Commit takes effect for pixels presented from cycle after frame_start edge; pixels already in the pipeline use their stage-1 descriptor snapshot.
- bg_color sampled at stage 2.
- Async reset asserted mid-frame: all outputs 0 immediately; first valid output two cycles after first pix_valid following deassertion.

## Test plan
- Reset, no writes, 1600 pixels of row 0 -> every out_color = bg_color (12'h123), out_hit = 0, latency exactly 2.
- Write sprite 0 {600, 800, en 1, 12'hF00}, full-disc mask; pixel (600,800) before frame_start -> bg; after frame_start -> out_hit 1, out_idx 0, 12'hF00; commit_done pulses once.
- Sprites 1 and 2 both centred (300,300), colours 12'h0F0/12'h00F -> pixel (300,300) gives out_idx 1, 12'h0F0; disable 1, commit -> out_idx 2.
- Sprite 3 at (0,0), all-ones mask -> pixel (63,63) hit, (64,0) and (0,64) miss, (1199,1599) miss (no wrap).
- wr_valid held in the frame_start cycle -> wr_ready 0, write accepted next cycle, visible only after the following frame_start.
- Assert rst low mid-line with out_valid 1 -> out_valid/out_color 0 at once; active descriptors cleared (pixel previously hit now bg).
